// File: rtl/pe_vector_pkg.sv
// rtl/pe_vector_pkg.sv - shared widths, helper function and beat flag type for the PE vector
package pe_vector_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) result++;
        return result;
    endfunction

    localparam int DEF_DATA_BITWIDTH     = 8;
    localparam int DEF_NUM_OF_CHANNEL    = 32;
    localparam int DEF_WEIGHT_DEPTH      = 16;
    localparam int DEF_ACC_BITWIDTH      = 32;
    localparam int DEF_OUT_BITWIDTH      = 16;
    localparam int DEF_BEAT_CNT_BITWIDTH = 8;

    localparam int WADDR_BITWIDTH    = clog2(DEF_WEIGHT_DEPTH);
    localparam int PROD_BITWIDTH     = 2 * DEF_DATA_BITWIDTH;
    localparam int TREE_LEVELS       = clog2(DEF_NUM_OF_CHANNEL);
    localparam int TREE_OUT_BITWIDTH = PROD_BITWIDTH + TREE_LEVELS;

    typedef struct packed {
        logic first;
        logic last;
    } beat_flag_t;

endpackage

// File: rtl/pe_vector_acc_pipelined_adder_tree.sv
// rtl/pe_vector_acc_pipelined_adder_tree.sv - registered signed reduction tree, one level per cycle
module pipelined_adder_tree
    import pe_vector_pkg::*;
#(
    parameter int IN_BITWIDTH = 16,
    parameter int NUM_INPUTS  = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            en,
    input  logic                                            in_valid,
    input  beat_flag_t                                      in_flags,
    input  logic [NUM_INPUTS*IN_BITWIDTH-1:0]               in_data,
    output logic                                            out_valid,
    output beat_flag_t                                      out_flags,
    output logic [IN_BITWIDTH+clog2(NUM_INPUTS)-1:0]        out_sum
);
    localparam int LEVELS = clog2(NUM_INPUTS);

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IW  = IN_BITWIDTH + l;
        localparam int OW  = IW + 1;
        localparam int CNT = NUM_INPUTS >> (l + 1);

        logic [2*CNT*IW-1:0] src;
        logic                src_valid;
        beat_flag_t          src_flags;
        logic [CNT*OW-1:0]   sum_q;
        logic                valid_q;
        beat_flag_t          flags_q;

        if (l == 0) begin : g_first
            assign src       = in_data;
            assign src_valid = in_valid;
            assign src_flags = in_flags;
        end else begin : g_next
            assign src       = g_lvl[l-1].sum_q;
            assign src_valid = g_lvl[l-1].valid_q;
            assign src_flags = g_lvl[l-1].flags_q;
        end

        // Each pair is sign-extended one bit so the sum can never overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                valid_q <= 1'b0;
                flags_q <= '0;
            end else if (en) begin
                for (int i = 0; i < CNT; i++) begin
                    sum_q[i*OW +: OW] <= OW'($signed(src[2*i*IW +: IW]))
                                       + OW'($signed(src[(2*i+1)*IW +: IW]));
                end
                valid_q <= src_valid;
                flags_q <= src_flags;
            end
        end
    end

    assign out_sum   = g_lvl[LEVELS-1].sum_q;
    assign out_valid = g_lvl[LEVELS-1].valid_q;
    assign out_flags = g_lvl[LEVELS-1].flags_q;

endmodule

// File: rtl/pe_vector_acc.sv
// rtl/pe_vector_acc.sv - weight-stationary dot-product engine with beat accumulation and post-processing
module pe_vector_acc
    import pe_vector_pkg::*;
#(
    parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
    parameter int NUM_OF_CHANNEL    = DEF_NUM_OF_CHANNEL,
    parameter int WEIGHT_DEPTH      = DEF_WEIGHT_DEPTH,
    parameter int ACC_BITWIDTH      = DEF_ACC_BITWIDTH,
    parameter int OUT_BITWIDTH      = DEF_OUT_BITWIDTH,
    parameter int BEAT_CNT_BITWIDTH = DEF_BEAT_CNT_BITWIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wght_we,
    input  logic [clog2(WEIGHT_DEPTH)-1:0]           wght_addr,
    input  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  wght_data,
    input  logic [BEAT_CNT_BITWIDTH-1:0]             cfg_beats,
    input  logic                                     cfg_relu,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NUM_OF_CHANNEL*DATA_BITWIDTH-1:0]  in_iact,
    input  logic [clog2(WEIGHT_DEPTH)-1:0]           in_waddr,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_BITWIDTH-1:0]                  out_data,
    output logic                                     out_sat
);
    localparam int LANES_W = NUM_OF_CHANNEL * DATA_BITWIDTH;
    localparam int PROD_W  = 2 * DATA_BITWIDTH;
    localparam int LEVELS  = clog2(NUM_OF_CHANNEL);
    localparam int TREE_W  = PROD_W + LEVELS;
    localparam logic signed [ACC_BITWIDTH-1:0] OUT_MAX =
        {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_BITWIDTH-1:0] OUT_MIN =
        {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

    logic adv;
    logic accept;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    logic [LANES_W-1:0] wght_bank [WEIGHT_DEPTH];
    logic [LANES_W-1:0] wght_row;

    // Writes are never stalled; a same-cycle reader still sees the old row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WEIGHT_DEPTH; i++) wght_bank[i] <= '0;
        end else if (wght_we) begin
            wght_bank[wght_addr] <= wght_data;
        end
    end
    assign wght_row = wght_bank[in_waddr];

    logic [BEAT_CNT_BITWIDTH-1:0] beat_cnt_q, group_beats_q, beats_eff, beat_cnt_inc;
    logic                         relu_q, relu_eff;
    beat_flag_t                   beat_flags;

    always_comb begin
        beat_flags.first = (beat_cnt_q == '0);
        beats_eff        = group_beats_q;
        relu_eff         = relu_q;
        if (beat_flags.first) begin
            beats_eff = (cfg_beats == '0) ? BEAT_CNT_BITWIDTH'(1) : cfg_beats;
            relu_eff  = cfg_relu;
        end
        beat_cnt_inc     = beat_cnt_q + 1'b1;
        beat_flags.last  = (beat_cnt_inc == beats_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q    <= '0;
            group_beats_q <= '0;
            relu_q        <= 1'b0;
        end else if (accept) begin
            if (beat_flags.first) begin
                group_beats_q <= beats_eff;
                relu_q        <= cfg_relu;
            end
            beat_cnt_q <= beat_flags.last ? '0 : beat_cnt_inc;
        end
    end

    logic signed [PROD_W-1:0] prod_d [NUM_OF_CHANNEL];
    logic [NUM_OF_CHANNEL*PROD_W-1:0] prod_q;
    logic                             prod_valid_q;
    beat_flag_t                       prod_flags_q;
    logic [LEVELS:0]                  relu_sr_q;

    always_comb begin
        for (int c = 0; c < NUM_OF_CHANNEL; c++) begin
            prod_d[c] = PROD_W'($signed(in_iact[c*DATA_BITWIDTH +: DATA_BITWIDTH]))
                      * PROD_W'($signed(wght_row[c*DATA_BITWIDTH +: DATA_BITWIDTH]));
        end
    end

    // The relu choice travels beside the beat so a new group cannot retarget an older result.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_flags_q <= '0;
            relu_sr_q    <= '0;
        end else if (adv) begin
            for (int c = 0; c < NUM_OF_CHANNEL; c++) prod_q[c*PROD_W +: PROD_W] <= prod_d[c];
            prod_valid_q <= in_valid;
            prod_flags_q <= beat_flags;
            relu_sr_q    <= {relu_sr_q[LEVELS-1:0], relu_eff};
        end
    end

    logic              tree_valid;
    beat_flag_t        tree_flags;
    logic [TREE_W-1:0] tree_sum;

    pipelined_adder_tree #(
        .IN_BITWIDTH (PROD_W),
        .NUM_INPUTS  (NUM_OF_CHANNEL)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (prod_valid_q),
        .in_flags  (prod_flags_q),
        .in_data   (prod_q),
        .out_valid (tree_valid),
        .out_flags (tree_flags),
        .out_sum   (tree_sum)
    );

    logic signed [ACC_BITWIDTH-1:0] sum_ext, acc_q, acc_next;
    logic [OUT_BITWIDTH-1:0]        post_data;
    logic                           post_sat;

    assign sum_ext = ACC_BITWIDTH'($signed(tree_sum));

    always_comb begin
        acc_next  = tree_flags.first ? sum_ext : acc_q + sum_ext;
        post_data = acc_next[OUT_BITWIDTH-1:0];
        post_sat  = 1'b0;
        if (relu_sr_q[LEVELS] && acc_next[ACC_BITWIDTH-1]) begin
            post_data = '0;
        end else if (acc_next > OUT_MAX) begin
            post_data = OUT_MAX[OUT_BITWIDTH-1:0];
            post_sat  = 1'b1;
        end else if (acc_next < OUT_MIN) begin
            post_data = OUT_MIN[OUT_BITWIDTH-1:0];
            post_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= tree_valid & tree_flags.last;
            if (tree_valid) begin
                acc_q <= acc_next;
                if (tree_flags.last) begin
                    out_data <= post_data;
                    out_sat  <= post_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_vector_acc.sv
// tb/tb_pe_vector_acc.sv - directed self-checking bench for pe_vector_acc
module tb_pe_vector_acc;
    import pe_vector_pkg::*;

    localparam int D   = 8;
    localparam int N   = 32;
    localparam int OUT = 16;

    logic                      clk;
    logic                      rst;
    logic                      wght_we;
    logic [WADDR_BITWIDTH-1:0] wght_addr;
    logic [N*D-1:0]            wght_data;
    logic [7:0]                cfg_beats;
    logic                      cfg_relu;
    logic                      in_valid;
    logic                      in_ready;
    logic [N*D-1:0]            in_iact;
    logic [WADDR_BITWIDTH-1:0] in_waddr;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT-1:0]            out_data;
    logic                      out_sat;

    pe_vector_acc #(
        .DATA_BITWIDTH     (D),
        .NUM_OF_CHANNEL    (N),
        .WEIGHT_DEPTH      (16),
        .ACC_BITWIDTH      (32),
        .OUT_BITWIDTH      (OUT),
        .BEAT_CNT_BITWIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wght_we   (wght_we),
        .wght_addr (wght_addr),
        .wght_data (wght_data),
        .cfg_beats (cfg_beats),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_iact   (in_iact),
        .in_waddr  (in_waddr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic signed [OUT-1:0] res_data_q [$];
    logic                  res_sat_q  [$];
    int                    res_cyc_q  [$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            res_data_q.push_back(out_data);
            res_sat_q.push_back(out_sat);
            res_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [N*D-1:0] fill(input logic [D-1:0] v);
        return {N{v}};
    endfunction

    task automatic clear_results();
        res_data_q.delete();
        res_sat_q.delete();
        res_cyc_q.delete();
    endtask

    task automatic write_row(input logic [WADDR_BITWIDTH-1:0] a, input logic [D-1:0] v);
        wght_we   = 1'b1;
        wght_addr = a;
        wght_data = fill(v);
        @(posedge clk);
        #1;
        wght_we   = 1'b0;
    endtask

    task automatic send_beat(input logic [D-1:0] v, input logic [WADDR_BITWIDTH-1:0] a, output int acc_cyc);
        bit got;
        got      = 1'b0;
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_iact  = fill(v);
        in_waddr = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL send_beat_timeout: in_ready=0 required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 300; i++) begin
            if (res_data_q.size() >= n) break;
            @(negedge clk);
        end
        if (res_data_q.size() < n) begin
            total_cnt++;
            $display("FAIL result_timeout: got %0d results required %0d", res_data_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pop_result(output logic signed [OUT-1:0] d, output logic s, output int c);
        if (res_data_q.size() > 0) begin
            d = res_data_q.pop_front();
            s = res_sat_q.pop_front();
            c = res_cyc_q.pop_front();
        end else begin
            d = 'x;
            s = 1'bx;
            c = -1;
        end
    endtask

    task automatic test_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data: got %0d required 0", out_data); else pass_cnt++;
        total_cnt++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b required 0", out_sat); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single();
        logic signed [OUT-1:0] d; logic s; int c, t;
        write_row(0, 8'd1);
        cfg_beats = 8'd1; cfg_relu = 1'b0;
        clear_results();
        send_beat(8'd1, 0, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd32) $display("FAIL single_data: got %0d required 32", d); else pass_cnt++;
        total_cnt++; if (s !== 1'b0) $display("FAIL single_sat: got %b required 0", s); else pass_cnt++;
        total_cnt++; if (c - t !== TREE_LEVELS + 2) $display("FAIL single_latency: got %0d required %0d", c - t, TREE_LEVELS + 2); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [OUT-1:0] d; logic s; int c, t;
        write_row(3, 8'd2);
        cfg_beats = 8'd3;
        clear_results();
        for (int i = 0; i < 3; i++) send_beat(8'd3, 3, t);
        wait_results(1);
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (res_data_q.size() !== 1) $display("FAIL b2b_count: got %0d results required 1", res_data_q.size()); else pass_cnt++;
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd576) $display("FAIL b2b_data: got %0d required 576", d); else pass_cnt++;
        total_cnt++; if (c - t !== TREE_LEVELS + 2) $display("FAIL b2b_latency: got %0d required %0d", c - t, TREE_LEVELS + 2); else pass_cnt++;
    endtask

    task automatic test_relu();
        logic signed [OUT-1:0] d; logic s; int c, t;
        write_row(1, 8'hFF);
        cfg_beats = 8'd1;
        clear_results();
        cfg_relu = 1'b0;
        send_beat(8'd5, 1, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== -16'sd160) $display("FAIL relu_off_data: got %0d required -160", d); else pass_cnt++;
        total_cnt++; if (s !== 1'b0) $display("FAIL relu_off_sat: got %b required 0", s); else pass_cnt++;
        cfg_relu = 1'b1;
        send_beat(8'd5, 1, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd0) $display("FAIL relu_on_data: got %0d required 0", d); else pass_cnt++;
        total_cnt++; if (s !== 1'b0) $display("FAIL relu_on_sat: got %b required 0", s); else pass_cnt++;
    endtask

    task automatic test_cfg_sample();
        logic signed [OUT-1:0] d; logic s; int c, t;
        clear_results();
        cfg_beats = 8'd2; cfg_relu = 1'b0;
        send_beat(8'd5, 1, t);
        cfg_beats = 8'd1; cfg_relu = 1'b1;
        send_beat(8'd5, 1, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== -16'sd320) $display("FAIL cfg_midgroup_data: got %0d required -320", d); else pass_cnt++;
        cfg_beats = 8'd0;
        send_beat(8'd5, 1, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd0) $display("FAIL cfg_zero_beats_data: got %0d required 0", d); else pass_cnt++;
        cfg_relu = 1'b0;
    endtask

    task automatic test_saturate();
        logic signed [OUT-1:0] d; logic s; int c, t;
        write_row(2, 8'd127);
        write_row(4, 8'h80);
        cfg_beats = 8'd4; cfg_relu = 1'b0;
        clear_results();
        for (int i = 0; i < 4; i++) send_beat(8'd127, 2, t);
        for (int i = 0; i < 4; i++) send_beat(8'd127, 4, t);
        wait_results(2);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd32767) $display("FAIL sat_pos_data: got %0d required 32767", d); else pass_cnt++;
        total_cnt++; if (s !== 1'b1) $display("FAIL sat_pos_flag: got %b required 1", s); else pass_cnt++;
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sh8000) $display("FAIL sat_neg_data: got %0d required -32768", d); else pass_cnt++;
        total_cnt++; if (s !== 1'b1) $display("FAIL sat_neg_flag: got %b required 1", s); else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        logic signed [OUT-1:0] d; logic s; int c;
        logic signed [OUT-1:0] held;
        bit ready_low, stable;
        cfg_beats = 8'd1; cfg_relu = 1'b0;
        clear_results();
        ready_low = 1'b1;
        stable    = 1'b1;
        fork
            begin
                int t;
                for (int k = 1; k <= 12; k++) send_beat(D'(k), 0, t);
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) @(negedge clk);
                    if (in_ready !== 1'b0) ready_low = 1'b0;
                    if (out_data !== held || out_valid !== 1'b1) stable = 1'b0;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        total_cnt++; if (ready_low !== 1'b1) $display("FAIL stall_in_ready: got high during stall required low"); else pass_cnt++;
        total_cnt++; if (stable !== 1'b1) $display("FAIL stall_hold: got changing output required stable %0d", held); else pass_cnt++;
        wait_results(12);
        for (int k = 1; k <= 12; k++) begin
            pop_result(d, s, c);
            total_cnt++; if (d !== OUT'(32 * k)) $display("FAIL stream_data_%0d: got %0d required %0d", k, d, 32 * k); else pass_cnt++;
        end
    endtask

    task automatic test_weight_collision();
        logic signed [OUT-1:0] d; logic s; int c, t;
        cfg_beats = 8'd1;
        clear_results();
        wght_we   = 1'b1;
        wght_addr = 0;
        wght_data = fill(8'd2);
        send_beat(8'd1, 0, t);
        wght_we   = 1'b0;
        send_beat(8'd1, 0, t);
        wait_results(2);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd32) $display("FAIL collide_old_row: got %0d required 32", d); else pass_cnt++;
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd64) $display("FAIL collide_new_row: got %0d required 64", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_group();
        logic signed [OUT-1:0] d; logic s; int c, t;
        cfg_beats = 8'd3;
        clear_results();
        send_beat(8'd1, 0, t);
        send_beat(8'd1, 0, t);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b required 0", out_valid); else pass_cnt++;
        cfg_beats = 8'd1;
        send_beat(8'd1, 0, t);
        wait_results(1);
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd0) $display("FAIL midreset_bank_cleared: got %0d required 0", d); else pass_cnt++;
        write_row(0, 8'd1);
        cfg_beats = 8'd3;
        for (int i = 0; i < 3; i++) send_beat(8'd2, 0, t);
        wait_results(1);
        repeat (12) @(posedge clk);
        #1;
        total_cnt++; if (res_data_q.size() !== 1) $display("FAIL midreset_count: got %0d results required 1", res_data_q.size()); else pass_cnt++;
        pop_result(d, s, c);
        total_cnt++; if (d !== 16'sd192) $display("FAIL midreset_data: got %0d required 192", d); else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        wght_we   = 1'b0;
        wght_addr = '0;
        wght_data = '0;
        cfg_beats = 8'd1;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        in_iact   = '0;
        in_waddr  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_relu();
        test_cfg_sample();
        test_saturate();
        test_back_pressure();
        test_weight_collision();
        test_reset_mid_group();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t required finish earlier", $time);
        $fatal(1);
    end

endmodule
